// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives every datapath enable and mux select from the state and latched opcode.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       ExtendSign,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  state_t     state_reg, state_next;
  logic [5:0] op_q_reg;
  logic       imm_logic;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_FETCH;
      op_q_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE)
        op_q_reg <= op;
    end
  end

  assign imm_logic = (op_q_reg == OP_ANDI) || (op_q_reg == OP_ORI);
  assign state_dbg = state_reg;

  // Outputs are forced to their idle values while rst is held, even though the
  // state register already reads FETCH, so no strobe leaks out during reset.
  always_comb begin
    state_next  = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    ExtendSign  = 1'b1;
    illegal_op  = 1'b0;
    if (!rst) begin
      case (state_reg)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          state_next = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (op)
            OP_LW, OP_SW:              state_next = S_MEMADR;
            OP_R:                      state_next = S_EXEC;
            OP_BEQ:                    state_next = S_BRANCH;
            OP_J:                      state_next = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI:  state_next = S_IEXEC;
            default: begin
              state_next = S_FETCH;
              illegal_op = 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_next = (op_q_reg == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_next = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          state_next = mem_ready ? S_FETCH : S_MEMWR;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_IEXEC: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUOp      = imm_logic ? 2'b11 : 2'b00;
          ExtendSign = !imm_logic;
          state_next = S_IWB;
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          ExtendSign = !imm_logic;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-instruction state paths are expanded
// from opcode class and wait counts, and every cycle is checked against a table.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ExtendSign, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_dbg;

  localparam logic [5:0] R_OP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J_OP = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, BAD = 6'b111111;
  localparam logic [17:0] RESET_OV = 18'h00002;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .ExtendSign(ExtendSign), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Bit map: 17 PCWrite, 16 PCWriteCond, 15 IorD, 14 MemRead, 13 MemWrite,
  // 12 IRWrite, 11 MemtoReg, 10 RegDst, 9 RegWrite, 8 ALUSrcA, 7:6 ALUSrcB,
  // 5:4 ALUOp, 3:2 PCSource, 1 ExtendSign, 0 illegal_op
  logic [17:0] dut_ov;
  assign dut_ov = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, ExtendSign, illegal_op};

  int          total = 0;
  int          bad = 0;
  int          exp_state = 0;
  logic [5:0]  exp_op = 6'd0;
  bit          chk_en = 1'b0;
  logic [17:0] e_ov;
  int          log_state[$];
  logic [17:0] log_ov[$];

  function automatic bit is_legal(input logic [5:0] o);
    return o inside {R_OP, LW, SW, BEQ, J_OP, ADDI, ANDI, ORI};
  endfunction

  // Spec output table by state number, for an instruction of opcode o
  function automatic logic [17:0] exp_out(input int st, input logic [5:0] o, input logic mr);
    logic [17:0] e;
    bit lg;
    e = RESET_OV;
    lg = (o == ANDI) || (o == ORI);
    case (st)
      0:  begin e[14] = 1; e[7:6] = 2'b01; e[12] = mr; e[17] = mr; end
      1:  begin e[7:6] = 2'b11; e[0] = !is_legal(o); end
      2:  begin e[8] = 1; e[7:6] = 2'b10; end
      3:  begin e[14] = 1; e[15] = 1; end
      4:  begin e[9] = 1; e[11] = 1; end
      5:  begin e[13] = 1; e[15] = 1; end
      6:  begin e[8] = 1; e[5:4] = 2'b10; end
      7:  begin e[9] = 1; e[10] = 1; end
      8:  begin e[8] = 1; e[5:4] = 2'b01; e[16] = 1; e[3:2] = 2'b01; end
      9:  begin e[17] = 1; e[3:2] = 2'b10; end
      10: begin e[8] = 1; e[7:6] = 2'b10; e[5:4] = lg ? 2'b11 : 2'b00; e[1] = !lg; end
      11: begin e[9] = 1; e[1] = !lg; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      e_ov = exp_out(exp_state, exp_op, mem_ready);
      chk($sformatf("outputs st%0d op%b", exp_state, exp_op), 32'(dut_ov), 32'(e_ov));
      chk("state_dbg", 32'(state_dbg), 32'(exp_state));
      log_state.push_back(int'(state_dbg));
      log_ov.push_back(dut_ov);
    end
  end

  task automatic step(input int st, input logic mr, input logic [5:0] o_in, input logic [5:0] instr);
    exp_state = st;
    exp_op    = instr;
    mem_ready = mr;
    op        = o_in;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] ro();
    return 6'($urandom);
  endfunction

  // fw / mw: wait cycles in FETCH and in the data access state
  task automatic run(input logic [5:0] o, input int fw, input int mw);
    log_state.delete();
    log_ov.delete();
    for (int i = 0; i <= fw; i++) step(0, i == fw, ro(), o);
    step(1, rb(), o, o);
    case (o)
      LW: begin
        step(2, rb(), ro(), o);
        for (int i = 0; i <= mw; i++) step(3, i == mw, ro(), o);
        step(4, rb(), ro(), o);
      end
      SW: begin
        step(2, rb(), ro(), o);
        for (int i = 0; i <= mw; i++) step(5, i == mw, ro(), o);
      end
      R_OP: begin step(6, rb(), ro(), o); step(7, rb(), ro(), o); end
      BEQ:  step(8, rb(), ro(), o);
      J_OP: step(9, rb(), ro(), o);
      ADDI, ANDI, ORI: begin step(10, rb(), ro(), o); step(11, rb(), ro(), o); end
      default: ;
    endcase
    $display("instr op=%b fetch_waits=%0d mem_waits=%0d cycles=%0d", o, fw, mw, log_state.size());
  endtask

  function automatic int count_bit(input int b);
    int n = 0;
    foreach (log_ov[i]) if (log_ov[i][b]) n++;
    return n;
  endfunction

  logic [5:0] legal_ops[8];

  initial begin
    legal_ops = '{R_OP, LW, SW, BEQ, J_OP, ADDI, ANDI, ORI};
    #1;
    chk("reset outputs", 32'(dut_ov), 32'(RESET_OV));
    chk("reset state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("release MemRead", 32'(MemRead), 32'd1);

    run(LW, 0, 0);
    chk("lw cycles", log_state.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("lw seq[%0d]", i), log_state[i], i);
    chk("lw RegWrite count", count_bit(9), 1);
    chk("lw MemtoReg at MEMWB", 32'(log_ov[4][11]), 32'd1);
    chk("lw ExtendSign count", count_bit(1), 5);

    run(R_OP, 2, 0);
    chk("fetch wait IRWrite count", count_bit(12), 1);
    chk("fetch wait IRWrite 3rd", 32'(log_ov[2][12]), 32'd1);
    chk("fetch wait PCWrite 3rd", 32'(log_ov[2][17]), 32'd1);
    chk("R cycles", log_state.size(), 6);

    run(ANDI, 0, 0);
    chk("andi IEXEC ExtendSign", 32'(log_ov[2][1]), 32'd0);
    chk("andi IEXEC ALUOp", 32'(log_ov[2][5:4]), 32'd3);
    chk("andi IWB ExtendSign", 32'(log_ov[3][1]), 32'd0);

    run(ADDI, 0, 0);
    chk("addi IEXEC ExtendSign", 32'(log_ov[2][1]), 32'd1);
    chk("addi IEXEC ALUOp", 32'(log_ov[2][5:4]), 32'd0);

    run(BAD, 0, 0);
    chk("illegal pulse count", count_bit(0), 1);
    chk("illegal in DECODE", 32'(log_ov[1][0]), 32'd1);
    chk("illegal cycles", log_state.size(), 2);
    chk("illegal no RegWrite", count_bit(9), 0);
    chk("illegal no MemWrite", count_bit(13), 0);

    run(ORI, 1, 0);
    run(BEQ, 0, 0);
    run(J_OP, 0, 0);
    run(SW, 0, 2);
    run(LW, 1, 3);

    // Reset asserted between edges while a store is waiting on memory
    log_state.delete();
    log_ov.delete();
    step(0, 1'b1, ro(), SW);
    step(1, rb(), SW, SW);
    step(2, rb(), ro(), SW);
    exp_state = 5;
    exp_op    = SW;
    mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("sw reset MemWrite", 32'(MemWrite), 32'd0);
    chk("sw reset state", 32'(state_dbg), 32'd0);
    chk("sw reset outputs", 32'(dut_ov), 32'(RESET_OV));
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("sw reset held MemWrite", 32'(MemWrite), 32'd0);
    chk("sw reset held state", 32'(state_dbg), 32'd0);
    rst = 1'b0;
    $display("instr op=%b reset during store wait", SW);

    run(BEQ, 0, 0);
    for (int k = 0; k < 8; k++)
      run(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 2));
    run(6'b010001, 0, 0);
    run(LW, 0, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
